result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter W, default 8: signed width of each drained output element.
REQ-002 Parameter ACC_W, default 16: signed width of each accumulator input.
REQ-003 Parameter N_MACS, default 4: number of MAC lanes consumed.
REQ-004 Parameter SHIFT, default 4, range 0..ACC_W-1: requantize right-shift amount.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 acc_in_0..acc_in_3  input  ACC_W each, signed: accumulator outputs of the upstream MAC array.
REQ-008 valid_in  input  N_MACS: per-lane level valid from the upstream array; bit i qualifies acc_in_i.
REQ-009 clear  input  1: synchronous job restart.
REQ-010 out_ready  input  1: downstream accepts the current element.
REQ-011 out_data  output  W, signed: requantized element.
REQ-012 out_idx  output  2: lane index of out_data.
REQ-013 out_valid  output  1: out_data/out_idx/out_last valid.
REQ-014 out_last  output  1: high with the final element (lane N_MACS-1).
REQ-015 done  output  1: one-cycle pulse after the last element is accepted.
REQ-016 sat_flag  output  1: sticky; any lane saturated in the current job.

Function
REQ-017 Lane i is captured at the rising clk edge where valid_in[i]=1 and its registered previous value is 0 (rising-edge detect, not level).
REQ-018 Capture stores the requantized value: r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_W+1 bits with arithmetic shift; no rounding term when SHIFT=0.
REQ-019 r saturates to [-2^(W-1), 2^(W-1)-1]; any saturation sets sat_flag.
REQ-020 Each lane is captured at most once per job; later rising edges on an already-captured lane are ignored.
REQ-021 FSM states: COLLECT, DRAIN, DONE.
REQ-022 COLLECT -> DRAIN at the edge where the last uncaptured lane is captured; out_valid=1 with lane 0 from that edge.
REQ-023 In DRAIN, lanes are emitted in order 0..N_MACS-1; the index advances only on an out_valid && out_ready edge.
REQ-024 While out_valid && !out_ready, out_data, out_idx and out_last are held stable.
REQ-025 Acceptance of lane N_MACS-1 -> DONE: out_valid=0, done=1 for exactly one cycle, then COLLECT with all capture flags cleared.
REQ-026 Valid_in rising edges during DRAIN or DONE are ignored, and the edge-detect registers still update.
REQ-027 sat_flag clears on entry to COLLECT from DONE; it is held through DRAIN.
REQ-028 clear=1 forces COLLECT, out_valid=0, done=0, and clears capture flags and sat_flag; clear has priority over a same-cycle capture or handshake.

Reset
REQ-029 rst_n=0 asynchronously forces state COLLECT and clears capture flags and edge-detect registers.
REQ-030 Under rst_n=0, outputs are out_data=0, out_idx=0, out_valid=0, out_last=0, done=0 and sat_flag=0.
REQ-031 A valid_in bit already high when rst_n deasserts counts as a rising edge on the first clock.
REQ-032 Reset mid-DRAIN discards all captured data; no partial element is emitted after release.

Configuration
REQ-033 RESULT_DRAIN_RELU_EN defined: negative r is replaced by 0 before storage; negative inputs never set sat_flag.
REQ-034 RESULT_DRAIN_RELU_EN undefined: signed r is passed through with saturation only.

Verification (SHIFT=4, W=8, ACC_W=16)
REQ-035 acc=20,30,50,70, valid_in bits rising on separate cycles with out_ready=1 -> out_data 1,2,3,4, out_idx 0..3, out_last only on idx 3, done pulse, sat_flag=0.
REQ-036 acc_in_0=2047 -> out_data=127 on idx 0 and sat_flag=1; acc_in_0=-4000 (ReLU undefined) -> -128 and sat_flag=1.
REQ-037 acc_in_1=-40 -> -2 with ReLU undefined and 0 with RESULT_DRAIN_RELU_EN defined.
REQ-038 Hold out_ready=0 for 5 cycles on idx 1 -> out_data/out_idx stable, no idx skipped, 4 elements total.
REQ-039 Re-pulse valid_in[0] after capture and during DRAIN -> no duplicate element and the job still completes with 4 elements.
REQ-040 Assert clear in the same cycle as the final capture -> remain in COLLECT, out_valid=0; rst_n low mid-DRAIN -> out_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module   : result_drain
// Purpose  : Collects one requantized result per MAC lane and drains them
//            in lane order over a valid/ready output port.
//            Each lane is captured once per job on a rising edge of its
//            valid_in bit. Capture applies rounding, an arithmetic right
//            shift and saturation to W bits. Once every lane is captured
//            the elements are emitted as lanes 0..N_MACS-1, followed by a
//            one-cycle done pulse.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            acc_in_0..3- signed accumulator values, ACC_W bits each
//            valid_in   - per-lane level valid, N_MACS bits
//            clear      - synchronous job restart
//            out_ready  - downstream accepts the current element
//            out_data   - requantized element, W bits signed
//            out_idx    - lane index of out_data
//            out_valid  - out_data/out_idx/out_last valid
//            out_last   - marks lane N_MACS-1
//            done       - one-cycle pulse after the last acceptance
//            sat_flag   - sticky saturation indicator for the current job
// Options  : RESULT_DRAIN_RELU_EN - when defined, negative results are
//            stored as 0 and never flag saturation.
// Revision : 1.0 - initial release
// ============================================================================
module result_drain #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int SHIFT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  input  logic                    clear,
  input  logic                    out_ready,
  output logic signed [W-1:0]     out_data,
  output logic [1:0]              out_idx,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    done,
  output logic                    sat_flag
);

  // One extra bit so the rounding add can never overflow.
  localparam int EXT_W = ACC_W + 1;
  // (2**SHIFT)/2 evaluates to 0 when SHIFT is 0, i.e. no rounding term.
  localparam logic signed [EXT_W-1:0] ROUND   = EXT_W'((2 ** SHIFT) / 2);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (W - 1)) - 1);
  localparam logic signed [W-1:0]     OUT_MAX = {1'b0, {(W-1){1'b1}}};
`ifndef RESULT_DRAIN_RELU_EN
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (W - 1)));
  localparam logic signed [W-1:0]     OUT_MIN = {1'b1, {(W-1){1'b0}}};
`endif
  localparam logic [1:0] LAST_IDX = 2'(N_MACS - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                state_q,      state_d;
  logic [N_MACS-1:0]     valid_prev_q, valid_prev_d;
  logic [N_MACS-1:0]     captured_q,   captured_d;
  logic signed [W-1:0]   data_q [N_MACS];
  logic signed [W-1:0]   data_d [N_MACS];
  logic [1:0]            idx_q,        idx_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  done_q,       done_d;
  logic                  sat_q,        sat_d;

  // --------------------------------------------------------------------------
  // Per-lane requantization
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_acc [4];
  logic signed [W-1:0]     w_rq  [N_MACS];
  logic [N_MACS-1:0]       w_lsat;

  assign w_acc[0] = acc_in_0;
  assign w_acc[1] = acc_in_1;
  assign w_acc[2] = acc_in_2;
  assign w_acc[3] = acc_in_3;

  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shr;
    logic                    w_pos_ovf;

    assign w_ext     = {w_acc[i][ACC_W-1], w_acc[i]};
    assign w_sum     = w_ext + ROUND;
    assign w_shr     = w_sum >>> SHIFT;
    assign w_pos_ovf = (w_shr > SAT_MAX);

`ifdef RESULT_DRAIN_RELU_EN
    // Negative results clamp to zero; that clamp is not a saturation event.
    assign w_rq[i]   = w_shr[EXT_W-1] ? '0 :
                       w_pos_ovf      ? OUT_MAX : w_shr[W-1:0];
    assign w_lsat[i] = w_pos_ovf;
`else
    logic w_neg_ovf;
    assign w_neg_ovf = (w_shr < SAT_MIN);
    assign w_rq[i]   = w_pos_ovf ? OUT_MAX :
                       w_neg_ovf ? OUT_MIN : w_shr[W-1:0];
    assign w_lsat[i] = w_pos_ovf | w_neg_ovf;
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [N_MACS-1:0] w_rise;
  logic [N_MACS-1:0] w_cap;

  always_comb begin
    // Edge detect runs in every state so a level held across DRAIN/DONE is
    // not mistaken for a fresh edge once collection resumes.
    w_rise       = valid_in & ~valid_prev_q;
    w_cap        = (state_q == S_COLLECT) ? (w_rise & ~captured_q) : '0;

    valid_prev_d = valid_in;
    state_d      = state_q;
    captured_d   = captured_q;
    data_d       = data_q;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    sat_d        = sat_q;

    case (state_q)
      S_COLLECT: begin
        captured_d = captured_q | w_cap;
        sat_d      = sat_q | (|(w_cap & w_lsat));
        for (int i = 0; i < N_MACS; i++) begin
          if (w_cap[i]) data_d[i] = w_rq[i];
        end
        if (&(captured_q | w_cap)) begin
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
          idx_d       = '0;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d    = S_COLLECT;
        captured_d = '0;
        sat_d      = 1'b0;
        idx_d      = '0;
      end
      default: begin
        state_d     = S_COLLECT;
        captured_d  = '0;
        out_valid_d = 1'b0;
        idx_d       = '0;
      end
    endcase

    // Restart overrides any capture or handshake in the same cycle.
    if (clear) begin
      state_d     = S_COLLECT;
      captured_d  = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      idx_d       = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_COLLECT;
      valid_prev_q <= '0;
      captured_q   <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
      for (int i = 0; i < N_MACS; i++) data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      valid_prev_q <= valid_prev_d;
      captured_q   <= captured_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
      data_q       <= data_d;
    end
  end

  // Data and index are both registered and frozen while stalled, so the
  // output word stays stable until it is accepted.
  assign out_data  = data_q[idx_q];
  assign out_idx   = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q & (idx_q == LAST_IDX);
  assign done      = done_q;
  assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_drain
// Purpose  : Self-checking bench for result_drain. Stimulus pushes expected
//            elements into a scoreboard queue; an independent monitor pops
//            and compares on every accepted output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_drain;

  localparam int W      = 8;
  localparam int ACC_W  = 16;
  localparam int N_MACS = 4;
  localparam int SHIFT  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [ACC_W-1:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
  logic [N_MACS-1:0]       valid_in;
  logic                    clear;
  logic                    out_ready;
  logic signed [W-1:0]     out_data;
  logic [1:0]              out_idx;
  logic                    out_valid, out_last, done, sat_flag;

  result_drain #(.W(W), .ACC_W(ACC_W), .N_MACS(N_MACS), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_in_0(acc_in_0), .acc_in_1(acc_in_1),
    .acc_in_2(acc_in_2), .acc_in_3(acc_in_3),
    .valid_in(valid_in), .clear(clear), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_last(out_last), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb_q[$];
  bit   sat_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   acc_v[4];

  // --------------------------------------------------------------------------
  // Reference model: round half up, floor divide by 2^SHIFT, clamp.
  // --------------------------------------------------------------------------
  function automatic void ref_model(input int acc, output int r, output bit s);
    int d, t, q, hi, lo;
    d  = 2 ** SHIFT;
    t  = acc + d / 2;
    q  = (t >= 0) ? (t / d) : -((-t + d - 1) / d);
    hi = 2 ** (W - 1) - 1;
    lo = -(2 ** (W - 1));
    s  = 1'b0;
`ifdef RESULT_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > hi) begin q = hi; s = 1'b1; end
    if (q < lo) begin q = lo; s = 1'b1; end
    r = q;
  endfunction

  function automatic int rand_acc();
    if ($urandom_range(0, 4) == 0) return int'($signed(ACC_W'($urandom)));
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic set_acc(input int lane, input int v);
    case (lane)
      0: acc_in_0 = ACC_W'(v);
      1: acc_in_1 = ACC_W'(v);
      2: acc_in_2 = ACC_W'(v);
      default: acc_in_3 = ACC_W'(v);
    endcase
  endtask

  task automatic push_job();
    exp_t e;
    int   r;
    bit   s, js;
    js = 1'b0;
    for (int i = 0; i < N_MACS; i++) begin
      ref_model(acc_v[i], r, s);
      js     |= s;
      e.data  = r;
      e.idx   = i;
      e.last  = (i == N_MACS - 1);
      sb_q.push_back(e);
    end
    sat_q.push_back(js);
  endtask

  // Scramble inputs of lanes already raised; capture must ignore these.
  task automatic noise();
    for (int i = 0; i < N_MACS; i++) if (valid_in[i]) set_acc(i, rand_acc());
  endtask

  // Raise every lane once; rnd shuffles order and inserts idle cycles.
  // repulse drops and re-raises lane 0 before the final lane.
  task automatic capture_job(input bit rnd, input bit repulse, input int n_lanes);
    int ord[4];
    int j, tmp;
    for (int k = 0; k < 4; k++) ord[k] = k;
    if (rnd) begin
      for (int k = 3; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
      end
    end
    for (int k = 0; k < n_lanes; k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; noise(); end
      if (repulse && k == N_MACS - 1) begin
        @(posedge clk); #1; valid_in[0] = 1'b0;
        @(posedge clk); #1; set_acc(0, acc_v[0] + 1000); valid_in[0] = 1'b1;
      end
      @(posedge clk); #1;
      set_acc(ord[k], acc_v[ord[k]]);
      valid_in[ord[k]] = 1'b1;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on idx 1,
  // 3: always ready while toggling valid_in[0].
  task automatic drain_job(input int mode);
    int stall;
    bit got;
    stall = 0;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
      else begin
        case (mode)
          1: out_ready = ($urandom_range(0, 3) != 0);
          2: begin
            if (out_valid && out_idx == 2'd1 && stall < 5) begin
              out_ready = 1'b0;
              stall++;
            end else out_ready = 1'b1;
          end
          3: begin
            out_ready   = 1'b1;
            valid_in[0] = ~valid_in[0];
            set_acc(0, rand_acc());
          end
          default: out_ready = 1'b1;
        endcase
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, required one within 300 cycles");
    end
    valid_in  = '0;
    out_ready = 1'b1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL element_count: %0d elements left unemitted, required 0", sb_q.size());
      sb_q.delete();
      sat_q.delete();
    end
    @(posedge clk); #1;
    n_chk++;
    if (sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: sat_flag=%b after job, required 0", sat_flag);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  bit                  prev_stall  = 1'b0;
  bit                  expect_done = 1'b0;
  logic signed [W-1:0] prev_data;
  logic [1:0]          prev_idx;
  logic                prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        n_chk++;
        if (!(done === 1'b1 && out_valid === 1'b0)) begin
          n_fail++;
          $display("FAIL done_pulse: done=%b out_valid=%b, required done=1 out_valid=0", done, out_valid);
        end
        expect_done = 1'b0;
      end else if (done !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: done=%b, required 0", done);
      end
      if (prev_stall) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_idx !== prev_idx || out_last !== prev_last) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%0d idx=%0d last=%b, required valid=1 data=%0d idx=%0d last=%b",
                   out_valid, out_data, out_idx, out_last, prev_data, prev_idx, prev_last);
        end
      end
      prev_stall = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          n_chk++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_elem: data=%0d idx=%0d, required no element", out_data, out_idx);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (int'(out_data) != e.data || int'(out_idx) != e.idx || out_last !== e.last) begin
              n_fail++;
              $display("FAIL elem: data=%0d idx=%0d last=%b, required data=%0d idx=%0d last=%b",
                       out_data, out_idx, out_last, e.data, e.idx, e.last);
            end
            if (e.last) begin
              bit es;
              es = (sat_q.size() != 0) ? sat_q.pop_front() : 1'b0;
              n_chk++;
              if (sat_flag !== es) begin
                n_fail++;
                $display("FAIL sat_flag: got %b, required %b", sat_flag, es);
              end
              expect_done = 1'b1;
            end
          end
        end else begin
          prev_stall = 1'b1;
          prev_data  = out_data;
          prev_idx   = out_idx;
          prev_last  = out_last;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit got;
    rst_n = 1'b0; valid_in = '0; clear = 1'b0; out_ready = 1'b1;
    acc_in_0 = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;
    #3;
    n_chk++;
    if (out_data !== '0 || out_idx !== 2'd0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        done !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%0d idx=%0d valid=%b last=%b done=%b sat=%b, required all 0",
               out_data, out_idx, out_valid, out_last, done, sat_flag);
    end
    #20 rst_n = 1'b1;

    // Basic job: lanes rise on separate cycles in order.
    acc_v = '{20, 30, 50, 70};
    push_job(); capture_job(1'b0, 1'b0, 4); drain_job(0);

    // Positive saturation, then negative saturation / ReLU.
    acc_v = '{2047, 5, -7, 100};
    push_job(); capture_job(1'b0, 1'b0, 4); drain_job(0);
    acc_v = '{-4000, -40, 16, 15};
    push_job(); capture_job(1'b1, 1'b0, 4); drain_job(0);

    // Stall on idx 1.
    acc_v = '{300, -300, 1000, -1000};
    push_job(); capture_job(1'b0, 1'b0, 4); drain_job(2);

    // Re-pulse lane 0 after capture and during drain.
    acc_v = '{64, 128, 192, 256};
    push_job(); capture_job(1'b0, 1'b1, 4); drain_job(3);

    // Clear in the same cycle as the final capture.
    acc_v = '{10, 20, 30, 40};
    capture_job(1'b0, 1'b0, 3);
    @(posedge clk); #1;
    set_acc(3, acc_v[3]); valid_in[3] = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_collect: out_valid=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
    end
    valid_in = '0;
    @(posedge clk); #1;
    acc_v = '{-1, 7, 8, 9};
    push_job(); capture_job(1'b1, 1'b0, 4); drain_job(1);

    // Reset mid-drain, with all valid bits held high through release.
    acc_v = '{111, 222, 333, 444};
    push_job(); capture_job(1'b0, 1'b0, 4);
    out_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (out_valid) got = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b out_data=%0d, required 0 and 0", out_valid, out_data);
    end
    sb_q.delete();
    sat_q.delete();
    acc_v = '{-555, 666, -77, 88};
    for (int i = 0; i < 4; i++) set_acc(i, acc_v[i]);
    valid_in  = '1;
    out_ready = 1'b1;
    push_job();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    drain_job(1);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 4; i++) acc_v[i] = rand_acc();
      push_job();
      capture_job(1'b1, ($urandom_range(0, 3) == 0), 4);
      drain_job(($urandom_range(0, 3) == 0) ? 3 : 1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
